// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the shift-and-add multiplier.
//    state_t : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//    CNT_W   : width of the iteration counter for an N-bit operand
package mult_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   function automatic int CNT_W(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/nAdder.sv
// nAdder: N-bit ripple adder with carry-in and carry-out, the multiplier's datapath adder.
//    a, b : N-bit addends
//    cin  : carry-in
//    sum  : N-bit sum
//    cout : carry-out
module nAdder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned NxN shift-and-add multiplier, latency N+1 cycles.
//    clk, rst  : clock, asynchronous active-high reset
//    start     : request; A/B sampled on the same edge
//    A, B      : multiplicand / multiplier (unsigned, N bits)
//    busy      : high while iterating
//    done      : one-cycle pulse, P valid from this cycle on
//    P         : 2N-bit product register
//    pend_full : pending operand slot occupied
// Optional build macro MULT_START_QUEUE_EN adds a one-deep pending operand slot so a
// start arriving during a run is queued instead of dropped.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] P,
   output logic           pend_full
);
   localparam int CW = CNT_W(N);
   state_t state_q, state_d;
   logic [N-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
   logic [2*N-1:0] acc_q, acc_d, p_q, p_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   add_b, sum;
   logic           cout, run, last, load, pend_w;
   logic [N-1:0]   ld_a, ld_b;
   nAdder #(.N(N)) u_add (
      .a    (acc_q[2*N-1:N]),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );
   assign run   = state_q == S_RUN;
   assign last  = cnt_q == CW'(N - 1);
   assign add_b = mplier_q[0] ? mcand_q : '0;
`ifdef MULT_START_QUEUE_EN
   logic [N-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic         pend_full_q, pend_full_d, pend_cap;
   assign pend_w = pend_full_q;
   // The slot is filled either by a start during a run (when empty) or by a start in
   // DONE while the slot's current contents are being consumed by the next run.
   always_comb begin
      pend_cap    = (run && start && !pend_full_q) || (state_q == S_DONE && pend_full_q && start);
      pend_a_d    = pend_cap ? A : pend_a_q;
      pend_b_d    = pend_cap ? B : pend_b_q;
      pend_full_d = run ? (pend_full_q | start) :
                    (state_q == S_DONE) ? (pend_full_q & start) : pend_full_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_a_q    <= '0;
         pend_b_q    <= '0;
         pend_full_q <= 1'b0;
      end else begin
         pend_a_q    <= pend_a_d;
         pend_b_q    <= pend_b_d;
         pend_full_q <= pend_full_d;
      end
   end
   assign ld_a = pend_full_q ? pend_a_q : A;
   assign ld_b = pend_full_q ? pend_b_q : B;
`else
   assign pend_w = 1'b0;
   assign ld_a   = A;
   assign ld_b   = B;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_RUN : S_IDLE;
         S_RUN:   state_d = last ? S_DONE : S_RUN;
         S_DONE:  state_d = (start || pend_w) ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      busy      = run;
      done      = state_q == S_DONE;
      P         = p_q;
      pend_full = pend_w;
   end
   // Datapath: a new operation loads operands and clears the accumulator; each RUN cycle
   // adds the gated multiplicand into the high half and shifts the N+1-bit result right.
   always_comb begin
      load     = (state_q == S_IDLE && start) || (state_q == S_DONE && (start || pend_w));
      mcand_d  = load ? ld_a : mcand_q;
      mplier_d = load ? ld_b : run ? (mplier_q >> 1) : mplier_q;
      acc_d    = load ? '0 : run ? {cout, sum, acc_q[N-1:1]} : acc_q;
      cnt_d    = load ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      p_d      = (run && last) ? acc_d : p_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
      end
   end
endmodule
